// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
// Iterative RV32M DIV/DIVU/REM/REMU controller. It borrows the EX-stage ALU
// subtractor one operation per cycle (abs of operands, 32 restoring-division
// steps, sign fix-up). It keeps its own remainder, quotient and divisor state.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request, sampled only in IDLE or DONE
//   op           funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend     rs1 value, captured with start
//   divisor      rs2 value, captured with start
//   flush        synchronous abort (priority over start)
//   busy         high while the sequence runs (pipeline stall)
//   done         one-cycle pulse, result valid in the same cycle
//   result       quotient or remainder, held until the next completion
//   alu_a/alu_b  ALU operands driven by this block
//   alu_control  ALU opcode: 0001 subtract, 1111 pass-a
//   alu_out      combinational ALU result
// -----------------------------------------------------------------------------
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    input  logic [XLEN-1:0] alu_out
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ABS_A = 3'd1,
        ST_ABS_B = 3'd2,
        ST_ITER  = 3'd3,
        ST_FIX   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b1111;
    localparam logic [4:0] CNT_LAST = 5'd31;

    state_t          state_r;
    logic [1:0]      op_r;
    logic [XLEN-1:0] dividend_r;   // becomes |dividend| after ABS_A
    logic [XLEN-1:0] divisor_r;    // becomes |divisor| after ABS_B
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [4:0]      cnt_r;
    logic            a_neg_r;      // original dividend sign
    logic            b_neg_r;      // original divisor sign
    logic            busy_r;
    logic            done_r;
    logic [XLEN-1:0] result_r;

    logic            sgn_s;
    logic            s_top_s;
    logic [XLEN-1:0] s_low_s;
    logic            accept_s;
    logic [XLEN-1:0] fix_val_s;
    logic            fix_neg_s;

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

    // Datapath decode for the current iteration and fix-up step.
    always_comb begin
        sgn_s     = ~op_r[0];
        // Partial remainder S = {R, Q[31]} is 33 bits; the top bit lives apart.
        s_top_s   = rem_r[XLEN-1];
        s_low_s   = {rem_r[XLEN-2:0], quo_r[XLEN-1]};
        // A wrapped subtraction shows up as alu_out > S; with S[32] set the
        // true S always covers the divisor.
        accept_s  = s_top_s | ~(alu_out > s_low_s);
        fix_val_s = op_r[1] ? rem_r : quo_r;
        if (op_r[1]) begin
            fix_neg_s = sgn_s & a_neg_r;
        end else begin
            fix_neg_s = sgn_s & (a_neg_r ^ b_neg_r);
        end
    end

    // ALU operand and opcode selection by state.
    always_comb begin
        alu_a       = {XLEN{1'b0}};
        alu_b       = {XLEN{1'b0}};
        alu_control = ALU_PASS;
        case (state_r)
            ST_ABS_A: begin
                alu_control = ALU_SUB;
                alu_b       = dividend_r;
            end
            ST_ABS_B: begin
                alu_control = ALU_SUB;
                alu_b       = divisor_r;
            end
            ST_ITER: begin
                alu_control = ALU_SUB;
                alu_a       = s_low_s;
                alu_b       = divisor_r;
            end
            ST_FIX: begin
                alu_control = ALU_SUB;
                alu_b       = fix_val_s;
            end
            default: begin
                alu_control = ALU_PASS;
                alu_a       = {XLEN{1'b0}};
                alu_b       = {XLEN{1'b0}};
            end
        endcase
    end

    // Sequencer FSM with registered busy/done/result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            op_r       <= 2'b00;
            dividend_r <= {XLEN{1'b0}};
            divisor_r  <= {XLEN{1'b0}};
            rem_r      <= {XLEN{1'b0}};
            quo_r      <= {XLEN{1'b0}};
            cnt_r      <= 5'd0;
            a_neg_r    <= 1'b0;
            b_neg_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= {XLEN{1'b0}};
        end else if (flush) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        op_r       <= op;
                        dividend_r <= dividend;
                        divisor_r  <= divisor;
                        a_neg_r    <= dividend[XLEN-1];
                        b_neg_r    <= divisor[XLEN-1];
                        if (divisor == {XLEN{1'b0}}) begin
                            // RISC-V defined divide-by-zero results.
                            result_r <= op[1] ? dividend : {XLEN{1'b1}};
                            state_r  <= ST_DONE;
                            busy_r   <= 1'b0;
                            done_r   <= 1'b1;
                        end else begin
                            state_r  <= ST_ABS_A;
                            busy_r   <= 1'b1;
                            done_r   <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                ST_ABS_A: begin
                    if (sgn_s && dividend_r[XLEN-1]) begin
                        dividend_r <= alu_out;
                    end else begin
                        dividend_r <= dividend_r;
                    end
                    state_r <= ST_ABS_B;
                end
                ST_ABS_B: begin
                    if (sgn_s && divisor_r[XLEN-1]) begin
                        divisor_r <= alu_out;
                    end else begin
                        divisor_r <= divisor_r;
                    end
                    rem_r   <= {XLEN{1'b0}};
                    quo_r   <= dividend_r;   // dividend bits shift out of Q
                    cnt_r   <= 5'd0;
                    state_r <= ST_ITER;
                end
                ST_ITER: begin
                    rem_r <= accept_s ? alu_out : s_low_s;
                    quo_r <= {quo_r[XLEN-2:0], accept_s};
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_ITER;
                    end
                end
                ST_FIX: begin
                    result_r <= fix_neg_s ? alu_out : fix_val_s;
                    state_r  <= ST_DONE;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_out;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_result;

    always #5 clk = ~clk;

    // Shared EX-stage ALU stand-in.
    assign alu_out = (alu_control == 4'b0001) ? (alu_a - alu_b) :
                     (alu_control == 4'b1111) ? alu_a : 32'd0;

    div_sequencer #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .dividend(dividend), .divisor(divisor), .flush(flush),
        .busy(busy), .done(done), .result(result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_out(alu_out)
    );

    // RV32M semantics from plain arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        case (o)
            2'b00: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
            2'b01: return a / b;
            2'b10: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return sa % sb;
            end
            default: return a % b;
        endcase
    endfunction

    // Drive start at the current (negedge) time, run until done or timeout.
    // lat counts edges from the sampling edge to the first done-high sample.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bcnt);
        start = 1'b1; op = o; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        bcnt = 0;
        while (!done && lat < 60) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        res = result;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
        dividend = 32'd0; divisor = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h, want 0 0 0", busy, done, result);
        end
        checks++;
        if (alu_control !== 4'b1111 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
            errors++;
            $display("FAIL reset_alu: got ctl=%b a=%h b=%h, want 1111 0 0", alu_control, alu_a, alu_b);
        end
        last_result = 32'd0;
    endtask

    task automatic test_directed();
        logic [1:0]  ops [8]  = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01};
        logic [31:0] as  [8]  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                                  32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bs  [8]  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
        logic [31:0] exp [8]  = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                                  32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] res;
        int lat, bcnt;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, bcnt);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h, want %h", i, res, exp[i]);
            end
            checks++;
            if (lat !== 36 || bcnt !== 35) begin
                errors++;
                $display("FAIL directed_timing[%0d]: got lat=%0d busy=%0d, want 36 35", i, lat, bcnt);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || result !== exp[i]) begin
                errors++;
                $display("FAIL directed_pulse[%0d]: got done=%b result=%h, want 0 %h", i, done, result, exp[i]);
            end
            last_result = exp[i];
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] res;
        int lat, bcnt;
        run_op(2'b00, 32'd5, 32'd0, res, lat, bcnt);
        checks++;
        if (res !== 32'hFFFF_FFFF || lat !== 1 || bcnt !== 0) begin
            errors++;
            $display("FAIL div_zero_div: got %h lat=%0d busy=%0d, want ffffffff 1 0", res, lat, bcnt);
        end
        @(negedge clk);
        run_op(2'b11, 32'd5, 32'd0, res, lat, bcnt);
        checks++;
        if (res !== 32'd5 || lat !== 1 || bcnt !== 0) begin
            errors++;
            $display("FAIL div_zero_remu: got %h lat=%0d busy=%0d, want 5 1 0", res, lat, bcnt);
        end
        last_result = 32'd5;
        @(negedge clk);
    endtask

    task automatic test_flush();
        int seen_done = 0;
        start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        // cycle 1 = ABS_A, 2 = ABS_B, 3 = ITER counter 0, so counter 10 at cycle 13
        repeat (12) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== last_result) begin
            errors++;
            $display("FAIL flush_abort: got busy=%b done=%b result=%h, want 0 0 %h", busy, done, result, last_result);
        end
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen_done++;
            @(negedge clk);
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL flush_quiet: got %0d active cycles, want 0", seen_done);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        start = 1'b1; op = 2'b00; dividend = 32'h1234_5678; divisor = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || alu_control !== 4'b1111) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b result=%h ctl=%b, want 0 0 0 1111",
                     busy, done, result, alu_control);
        end
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles, want 0", seen);
        end
        last_result = 32'd0;
    endtask

    task automatic test_start_busy();
        int lat = 1;
        start = 1'b1; op = 2'b01; dividend = 32'd1000; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 60) begin
            if (lat == 10) begin
                start = 1'b1; op = 2'b11; dividend = 32'd55; divisor = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (result !== 32'd142 || lat !== 36) begin
            errors++;
            $display("FAIL start_busy: got %h lat=%0d, want 0000008e 36", result, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        int lat, bcnt;
        run_op(2'b01, 32'd99, 32'd10, res, lat, bcnt);
        checks++;
        if (res !== 32'd9 || lat !== 36) begin
            errors++;
            $display("FAIL b2b_first: got %h lat=%0d, want 9 36", res, lat);
        end
        // Now in the DONE cycle: start again immediately.
        start = 1'b1; op = 2'b10; dividend = 32'hFFFF_FF9C; divisor = 32'd7;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_nogap: got busy=%b done=%b, want 1 0", busy, done);
        end
        lat = 1;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (result !== 32'hFFFF_FFFE || lat !== 36) begin
            errors++;
            $display("FAIL b2b_second: got %h lat=%0d, want fffffffe 36", result, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] a, b, res, exp;
        logic [1:0]  o;
        int lat, bcnt;
        for (int i = 0; i < 1000; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                default: b = b;
            endcase
            exp = ref_div(o, a, b);
            run_op(o, a, b, res, lat, bcnt);
            checks++;
            if (res !== exp || lat !== ((b == 32'd0) ? 1 : 36)) begin
                errors++;
                $display("FAIL random[%0d] op=%b a=%h b=%h: got %h lat=%0d, want %h", i, o, a, b, res, lat, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_flush();
        test_reset_mid();
        test_start_busy();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
